// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: one outstanding instruction-memory fetch, a single-entry
// output buffer to decode, and branch redirects that flush and drop in-flight responses.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [PC_W-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            flush,
  output logic            misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, r_fetch_pc, r_out_pc;
  logic [31:0]     r_out_instr;
  logic            r_drop, r_flush, r_misalign;
  logic            w_redir, w_accept;
  logic [PC_W-1:0] w_tgt;

  // IDLE only exists for the single cycle after reset, so a redirect there is never taken.
  assign w_redir  = PcSel && (r_state != IDLE);
  assign w_tgt    = BrPC[PC_W-1:0];
  assign w_accept = (r_state == WAIT) && rsp_valid && !r_drop && !w_redir;

  if (PC_W < 32) begin : g_unused
    logic w_unused_brpc;
    assign w_unused_brpc = ^BrPC[31:PC_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = REQ;
      REQ:  if (req_ready) w_next = WAIT;
      WAIT: begin
        if (w_redir)        w_next = rsp_valid ? REQ : WAIT;
        else if (rsp_valid) w_next = r_drop ? REQ : HOLD;
      end
      HOLD: if (w_redir || out_ready) w_next = REQ;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_valid = (r_state == REQ);
    out_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_fetch_pc  <= '0;
      r_drop      <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_flush <= w_redir;
      if (w_redir && (BrPC[1:0] != 2'b00)) r_misalign <= 1'b1;

      if (w_redir)       r_pc <= w_tgt;
      else if (w_accept) r_pc <= r_pc + PC_W'(4);

      // A redirect racing an accepted request leaves a stale response in flight.
      if (r_state == REQ && req_ready) begin
        r_fetch_pc <= r_pc;
        r_drop     <= w_redir;
      end else if (r_state == WAIT) begin
        if (rsp_valid)    r_drop <= 1'b0;
        else if (w_redir) r_drop <= 1'b1;
      end

      if (w_accept) begin
        r_out_pc    <= r_fetch_pc;
        r_out_instr <= rsp_instr;
      end
    end
  end

  assign req_addr     = r_pc;
  assign out_pc       = r_out_pc;
  assign out_instr    = r_out_instr;
  assign flush        = r_flush;
  assign misalign_err = r_misalign;

endmodule
